// File: rtl/rv_trace_buf_if.sv
// rv_trace_buf_if: retire-capture inputs and record drain stream of the retire-trace buffer.
interface rv_trace_buf_if #(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int DEPTH            = 16
);
    logic                        i_retire;
    logic [IADDR_SPACE_BITS-2:0] i_pc;
    logic [31:0]                 i_instr;
    logic                        i_reg_write;
    logic [31:0]                 i_reg_data;
    logic                        i_mem_read;
    logic                        i_mem_write;
    logic [31:0]                 i_mem_addr;
    logic                        i_trigger;
    logic                        i_clear;
    logic                        o_rec_valid;
    logic                        i_rec_ready;
    logic [IADDR_SPACE_BITS-1:0] o_rec_pc;
    logic [31:0]                 o_rec_instr;
    logic [31:0]                 o_rec_data;
    logic [31:0]                 o_rec_addr;
    logic [4:0]                  o_rec_flags;
    logic [$clog2(DEPTH):0]      o_count;
    logic [15:0]                 o_drop_cnt;
    logic                        o_overflow;
    logic [1:0]                  o_state;

    modport master (
        output i_retire, i_pc, i_instr, i_reg_write, i_reg_data, i_mem_read, i_mem_write,
               i_mem_addr, i_trigger, i_clear, i_rec_ready,
        input  o_rec_valid, o_rec_pc, o_rec_instr, o_rec_data, o_rec_addr, o_rec_flags,
               o_count, o_drop_cnt, o_overflow, o_state
    );
    modport slave (
        input  i_retire, i_pc, i_instr, i_reg_write, i_reg_data, i_mem_read, i_mem_write,
               i_mem_addr, i_trigger, i_clear, i_rec_ready,
        output o_rec_valid, o_rec_pc, o_rec_instr, o_rec_data, o_rec_addr, o_rec_flags,
               o_count, o_drop_cnt, o_overflow, o_state
    );
endinterface

// File: rtl/rv_trace_buf.sv
// rv_trace_buf: retire-trace FIFO with a trigger FSM that freezes capture POST_TRIG records after an event.
module rv_trace_buf #(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int DEPTH            = 16,
    parameter int POST_TRIG        = 4
) (
    input logic           i_clk,
    input logic           i_reset_n,
    rv_trace_buf_if.slave trc
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = IADDR_SPACE_BITS - 1 + 96 + 5;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {ARMED = 2'd0, TRIGGERED = 2'd1, STOPPED = 2'd2, UNUSED = 2'd3} state_t;

    logic [RW-1:0] mem [DEPTH];
    logic [RW-1:0] rec_in, head;
    logic [AW:0]   wr_ptr, rd_ptr, post_cnt, post_nx;
    state_t        state, state_nx;
    logic [15:0]   drop_cnt;
    logic          overflow, gap;
    logic          empty, full, pop, capture, push, drop, trig;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
    assign pop     = !empty && trc.i_rec_ready;
    assign capture = trc.i_retire && state != STOPPED;
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;
    assign trig    = trc.i_trigger || (trc.i_retire && trc.i_instr == EBREAK);

    // Record layout: pc[IADDR-1:1] | instr | data | addr | flags; data/addr masked here so the drain never sees stale operands
    assign rec_in = {trc.i_pc, trc.i_instr,
                     trc.i_reg_write ? trc.i_reg_data : 32'd0,
                     (trc.i_mem_read || trc.i_mem_write) ? trc.i_mem_addr : 32'd0,
                     gap, state == ARMED && trig, trc.i_mem_write, trc.i_mem_read, trc.i_reg_write};
    assign head = mem[rd_ptr[AW-1:0]];

    assign trc.o_rec_valid = !empty;
    assign trc.o_rec_pc    = {head[RW-1 -: IADDR_SPACE_BITS-1], 1'b0};
    assign trc.o_rec_instr = head[100:69];
    assign trc.o_rec_data  = head[68:37];
    assign trc.o_rec_addr  = head[36:5];
    assign trc.o_rec_flags = head[4:0];
    assign trc.o_count     = wr_ptr - rd_ptr;
    assign trc.o_drop_cnt  = drop_cnt;
    assign trc.o_overflow  = overflow;
    assign trc.o_state     = state;

    always_comb begin
        state_nx = state;
        post_nx  = post_cnt;
        case (state)
            ARMED: if (trig) begin
                post_nx  = (AW+1)'(POST_TRIG);
                state_nx = POST_TRIG == 0 ? STOPPED : TRIGGERED;
            end
            TRIGGERED: if (capture) begin
                post_nx  = post_cnt - (AW+1)'(1);
                state_nx = post_cnt == (AW+1)'(1) ? STOPPED : TRIGGERED;
            end
            STOPPED: state_nx = STOPPED;
            default: state_nx = ARMED;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            post_cnt <= '0;
            state    <= ARMED;
            drop_cnt <= '0;
            overflow <= 1'b0;
            gap      <= 1'b0;
        end else if (trc.i_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            post_cnt <= '0;
            state    <= ARMED;
            drop_cnt <= '0;
            overflow <= 1'b0;
            gap      <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + (AW+1)'(push);
            rd_ptr   <= rd_ptr + (AW+1)'(pop);
            post_cnt <= post_nx;
            state    <= state_nx;
            drop_cnt <= drop_cnt + 16'(drop && drop_cnt != 16'hFFFF);
            overflow <= overflow || drop;
            gap      <= drop || (gap && !push);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !trc.i_clear) mem[wr_ptr[AW-1:0]] <= rec_in;
    end
endmodule

// File: tb/tb_rv_trace_buf.sv
// tb_rv_trace_buf: directed and randomized checks of rv_trace_buf against a queue-based reference model.
module tb_rv_trace_buf;
    localparam int IAW = 32;
    localparam int DEPTH = 16;
    localparam int POST_TRIG = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] data;
        logic [31:0] addr;
        logic [4:0]  flags;
    } rec_t;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b1;
    always #5 i_clk = ~i_clk;

    rv_trace_buf_if #(.IADDR_SPACE_BITS(IAW), .DEPTH(DEPTH)) bus ();
    rv_trace_buf #(.IADDR_SPACE_BITS(IAW), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .trc(bus.slave)
    );

    rec_t q[$];
    int   m_drops, m_state, m_left;
    bit   m_ovf, m_gap;
    int   total = 0;
    int   bad = 0;

    task automatic model_clear();
        q.delete();
        m_drops = 0;
        m_ovf = 0;
        m_gap = 0;
        m_state = 0;
        m_left = 0;
    endtask

    // Applies the current inputs to the model, then advances the DUT one edge and settles.
    task automatic cycle();
        rec_t r;
        bit pop, trg, cap, full;
        pop = q.size() > 0 && bus.i_rec_ready;
        if (bus.i_clear) model_clear();
        else begin
            trg = bus.i_trigger || (bus.i_retire && bus.i_instr == EBREAK);
            cap = bus.i_retire && m_state != 2;
            full = q.size() == DEPTH;
            r.pc = {bus.i_pc, 1'b0};
            r.instr = bus.i_instr;
            r.data = bus.i_reg_write ? bus.i_reg_data : 32'd0;
            r.addr = (bus.i_mem_read || bus.i_mem_write) ? bus.i_mem_addr : 32'd0;
            r.flags = {m_gap, m_state == 0 && trg, bus.i_mem_write, bus.i_mem_read, bus.i_reg_write};
            if (pop) void'(q.pop_front());
            if (cap && (!full || pop)) begin
                q.push_back(r);
                m_gap = 0;
            end else if (cap) begin
                if (m_drops < 65535) m_drops++;
                m_ovf = 1;
                m_gap = 1;
            end
            if (m_state == 0 && trg) begin
                m_left = POST_TRIG;
                m_state = POST_TRIG == 0 ? 2 : 1;
            end else if (m_state == 1 && cap) begin
                m_left--;
                if (m_left == 0) m_state = 2;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        bus.i_retire = 0;
        bus.i_trigger = 0;
        bus.i_clear = 0;
    endtask

    task automatic drive_rand(input bit retire, input bit allow_ebreak);
        bus.i_retire = retire;
        bus.i_pc = (IAW-1)'($urandom);
        bus.i_instr = $urandom;
        if (allow_ebreak && $urandom_range(0, 15) == 0) bus.i_instr = EBREAK;
        if (!allow_ebreak && bus.i_instr == EBREAK) bus.i_instr = 32'h0000_0013;
        bus.i_reg_write = 1'($urandom);
        bus.i_reg_data = $urandom;
        bus.i_mem_read = 1'($urandom);
        bus.i_mem_write = !bus.i_mem_read && $urandom_range(0, 1) == 1;
        bus.i_mem_addr = $urandom;
        bus.i_trigger = 0;
        bus.i_clear = 0;
    endtask

    task automatic clear_cycle();
        idle();
        bus.i_clear = 1;
        cycle();
        bus.i_clear = 0;
    endtask

    task automatic test_reset();
        idle();
        #2 i_reset_n = 0;
        model_clear();
        #3;
        total++;
        if ({bus.o_rec_valid, bus.o_count, bus.o_drop_cnt, bus.o_overflow, bus.o_state} !== '0) begin
            bad++;
            $display("FAIL reset got valid=%b count=%0d drop=%0d ovf=%b state=%0d want all zero",
                     bus.o_rec_valid, bus.o_count, bus.o_drop_cnt, bus.o_overflow, bus.o_state);
        end
        @(posedge i_clk);
        #1 i_reset_n = 1;
    endtask

    task automatic test_order();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100;
        pcs[1] = 32'h104;
        pcs[2] = 32'h108;
        bus.i_rec_ready = 1;
        for (int i = 0; i < 3; i++) begin
            drive_rand(1, 0);
            bus.i_pc = pcs[i][IAW-1:1];
            bus.i_instr = 32'h0010_8093;
            cycle();
            total++;
            if (bus.o_rec_valid !== 1'b1 || bus.o_rec_pc !== pcs[i] || bus.o_rec_instr !== 32'h0010_8093
                || bus.o_count !== CW'(1)) begin
                bad++;
                $display("FAIL order%0d got valid=%b pc=%h instr=%h count=%0d want valid=1 pc=%h instr=00108093 count=1",
                         i, bus.o_rec_valid, bus.o_rec_pc, bus.o_rec_instr, bus.o_count, pcs[i]);
            end
        end
        idle();
        cycle();
        total++;
        if (bus.o_count !== CW'(0) || bus.o_rec_valid !== 1'b0) begin
            bad++;
            $display("FAIL order_drain got count=%0d valid=%b want 0 0", bus.o_count, bus.o_rec_valid);
        end
    endtask

    task automatic test_overflow();
        clear_cycle();
        bus.i_rec_ready = 0;
        repeat (DEPTH + 3) begin
            drive_rand(1, 0);
            cycle();
        end
        idle();
        total++;
        if (bus.o_count !== CW'(DEPTH) || bus.o_drop_cnt !== 16'd3 || bus.o_overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow got count=%0d drop=%0d ovf=%b want %0d 3 1",
                     bus.o_count, bus.o_drop_cnt, bus.o_overflow, DEPTH);
        end
        bus.i_rec_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if ({bus.o_rec_pc, bus.o_rec_instr, bus.o_rec_data, bus.o_rec_addr, bus.o_rec_flags}
                !== {q[0].pc, q[0].instr, q[0].data, q[0].addr, q[0].flags}) begin
                bad++;
                $display("FAIL overflow_drain%0d got pc=%h instr=%h flags=%b want pc=%h instr=%h flags=%b",
                         i, bus.o_rec_pc, bus.o_rec_instr, bus.o_rec_flags, q[0].pc, q[0].instr, q[0].flags);
            end
            cycle();
        end
        drive_rand(1, 0);
        bus.i_rec_ready = 0;
        cycle();
        total++;
        if (bus.o_rec_valid !== 1'b1 || bus.o_rec_flags[4] !== 1'b1) begin
            bad++;
            $display("FAIL gap_set got valid=%b gap=%b want 1 1", bus.o_rec_valid, bus.o_rec_flags[4]);
        end
        drive_rand(1, 0);
        bus.i_rec_ready = 1;
        cycle();
        total++;
        if (bus.o_rec_valid !== 1'b1 || bus.o_rec_flags[4] !== 1'b0 || bus.o_rec_instr !== q[0].instr) begin
            bad++;
            $display("FAIL gap_clear got valid=%b gap=%b instr=%h want 1 0 %h",
                     bus.o_rec_valid, bus.o_rec_flags[4], bus.o_rec_instr, q[0].instr);
        end
        idle();
        cycle();
    endtask

    task automatic test_full_pushpop();
        clear_cycle();
        bus.i_rec_ready = 0;
        repeat (DEPTH) begin
            drive_rand(1, 0);
            cycle();
        end
        drive_rand(1, 0);
        bus.i_rec_ready = 1;
        cycle();
        total++;
        if (bus.o_count !== CW'(DEPTH) || bus.o_drop_cnt !== 16'd0 || bus.o_rec_instr !== q[0].instr) begin
            bad++;
            $display("FAIL full_pushpop got count=%0d drop=%0d instr=%h want %0d 0 %h",
                     bus.o_count, bus.o_drop_cnt, bus.o_rec_instr, DEPTH, q[0].instr);
        end
        idle();
        repeat (DEPTH) cycle();
    endtask

    task automatic test_trigger();
        clear_cycle();
        bus.i_rec_ready = 0;
        drive_rand(1, 0);
        bus.i_instr = EBREAK;
        cycle();
        total++;
        if (bus.o_state !== 2'd1) begin
            bad++;
            $display("FAIL trig_state got %0d want 1", bus.o_state);
        end
        repeat (10) begin
            drive_rand(1, 0);
            cycle();
        end
        idle();
        total++;
        if (bus.o_count !== CW'(5) || bus.o_state !== 2'd2 || bus.o_drop_cnt !== 16'd0 || bus.o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL trig_stop got count=%0d state=%0d drop=%0d ovf=%b want 5 2 0 0",
                     bus.o_count, bus.o_state, bus.o_drop_cnt, bus.o_overflow);
        end
        bus.i_rec_ready = 1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.o_rec_instr !== q[0].instr || bus.o_rec_flags[3] !== (i == 0)) begin
                bad++;
                $display("FAIL trig_rec%0d got instr=%h trig=%b want %h %b",
                         i, bus.o_rec_instr, bus.o_rec_flags[3], q[0].instr, i == 0);
            end
            cycle();
        end
    endtask

    task automatic test_mem();
        clear_cycle();
        bus.i_rec_ready = 0;
        drive_rand(1, 0);
        bus.i_instr = 32'h0081_2283;
        {bus.i_reg_write, bus.i_mem_read, bus.i_mem_write} = 3'b110;
        bus.i_mem_addr = 32'h2008;
        bus.i_reg_data = 32'hDEAD_BEEF;
        cycle();
        drive_rand(1, 0);
        bus.i_instr = 32'h0051_2423;
        {bus.i_reg_write, bus.i_mem_read, bus.i_mem_write} = 3'b001;
        bus.i_mem_addr = 32'h3010;
        bus.i_reg_data = 32'h1234_5678;
        cycle();
        idle();
        total++;
        if (bus.o_rec_flags !== 5'b00011 || bus.o_rec_addr !== 32'h2008 || bus.o_rec_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL mem_load got flags=%b addr=%h data=%h want 00011 00002008 deadbeef",
                     bus.o_rec_flags, bus.o_rec_addr, bus.o_rec_data);
        end
        bus.i_rec_ready = 1;
        cycle();
        total++;
        if (bus.o_rec_flags !== 5'b00100 || bus.o_rec_addr !== 32'h3010 || bus.o_rec_data !== 32'd0) begin
            bad++;
            $display("FAIL mem_store got flags=%b addr=%h data=%h want 00100 00003010 00000000",
                     bus.o_rec_flags, bus.o_rec_addr, bus.o_rec_data);
        end
        cycle();
    endtask

    task automatic test_clear();
        clear_cycle();
        bus.i_rec_ready = 0;
        repeat (DEPTH) begin
            drive_rand(1, 0);
            cycle();
        end
        drive_rand(1, 0);
        bus.i_instr = EBREAK;
        cycle();
        repeat (POST_TRIG + 2) begin
            drive_rand(1, 0);
            cycle();
        end
        total++;
        if (bus.o_state !== 2'd2 || bus.o_count !== CW'(DEPTH) || bus.o_drop_cnt !== 16'(POST_TRIG + 1)) begin
            bad++;
            $display("FAIL clear_setup got state=%0d count=%0d drop=%0d want 2 %0d %0d",
                     bus.o_state, bus.o_count, bus.o_drop_cnt, DEPTH, POST_TRIG + 1);
        end
        drive_rand(1, 0);
        bus.i_instr = EBREAK;
        bus.i_trigger = 1;
        bus.i_clear = 1;
        cycle();
        idle();
        total++;
        if ({bus.o_rec_valid, bus.o_count, bus.o_drop_cnt, bus.o_overflow, bus.o_state} !== '0) begin
            bad++;
            $display("FAIL clear got valid=%b count=%0d drop=%0d ovf=%b state=%0d want all zero",
                     bus.o_rec_valid, bus.o_count, bus.o_drop_cnt, bus.o_overflow, bus.o_state);
        end
        cycle();
        total++;
        if (bus.o_count !== CW'(0) || bus.o_rec_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_nopush got count=%0d valid=%b want 0 0", bus.o_count, bus.o_rec_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_rand($urandom_range(0, 9) < 7, 1);
            bus.i_trigger = $urandom_range(0, 49) == 0;
            bus.i_clear = $urandom_range(0, 29) == 0;
            bus.i_rec_ready = $urandom_range(0, 1) == 1;
            cycle();
            total++;
            if ({bus.o_count, bus.o_rec_valid, bus.o_drop_cnt, bus.o_overflow, bus.o_state}
                !== {CW'(q.size()), q.size() > 0, 16'(m_drops), m_ovf, 2'(m_state)}) begin
                bad++;
                $display("FAIL rand_stat%0d got count=%0d valid=%b drop=%0d ovf=%b state=%0d want %0d %b %0d %b %0d",
                         i, bus.o_count, bus.o_rec_valid, bus.o_drop_cnt, bus.o_overflow, bus.o_state,
                         q.size(), q.size() > 0, m_drops, m_ovf, m_state);
            end
            if (q.size() > 0) begin
                total++;
                if ({bus.o_rec_pc, bus.o_rec_instr, bus.o_rec_data, bus.o_rec_addr, bus.o_rec_flags}
                    !== {q[0].pc, q[0].instr, q[0].data, q[0].addr, q[0].flags}) begin
                    bad++;
                    $display("FAIL rand_head%0d got %h %h %h %h %b want %h %h %h %h %b", i,
                             bus.o_rec_pc, bus.o_rec_instr, bus.o_rec_data, bus.o_rec_addr, bus.o_rec_flags,
                             q[0].pc, q[0].instr, q[0].data, q[0].addr, q[0].flags);
                end
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        clear_cycle();
        bus.i_rec_ready = 0;
        repeat (3) begin
            drive_rand(1, 0);
            cycle();
        end
        idle();
        test_reset();
    endtask

    initial begin
        bus.i_retire = 0;
        bus.i_pc = '0;
        bus.i_instr = '0;
        bus.i_reg_write = 0;
        bus.i_reg_data = '0;
        bus.i_mem_read = 0;
        bus.i_mem_write = 0;
        bus.i_mem_addr = '0;
        bus.i_trigger = 0;
        bus.i_clear = 0;
        bus.i_rec_ready = 0;
        test_reset();
        test_order();
        test_overflow();
        test_full_pushpop();
        test_trigger();
        test_mem();
        test_clear();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
